// File: rtl/mem_interface.sv
// mem_interface: single-transaction memory bus sequencer between Control and word-addressed memory.
// Optional MEM_IF_TIMEOUT_EN aborts bus accesses left unacknowledged for TIMEOUT cycles.
module mem_interface #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              iClk,
  input  logic              nRst,
  input  logic [ADDR_W-1:0] iAddr,
  input  logic              iRead,
  input  logic              iWrite,
  input  logic [DATA_W-1:0] iWData,
  output logic [DATA_W-1:0] oRData,
  output logic              oRdy,
  output logic              oErr,
  output logic [ADDR_W-1:0] oBusAddr,
  output logic [DATA_W-1:0] oBusWData,
  output logic              oBusRE,
  output logic              oBusWE,
  input  logic              iBusAck,
  input  logic [DATA_W-1:0] iBusRData
);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t state, next;
  logic op_rd, op_wr, acc, tmo, to_flag;
  assign acc = state == IDLE && (iRead ^ iWrite);
`ifdef MEM_IF_TIMEOUT_EN
  logic [7:0] cnt;
  assign tmo = state == REQ && !iBusAck && cnt == 8'(TIMEOUT - 1);
  always_ff @(posedge iClk)
    if (!nRst) begin
      cnt     <= '0;
      to_flag <= 1'b0;
    end else begin
      if (acc) cnt <= '0;
      else if (state == REQ && !iBusAck && cnt != 8'(TIMEOUT)) cnt <= cnt + 8'd1;
      to_flag <= tmo;
    end
`else
  assign tmo     = 1'b0;
  assign to_flag = 1'b0;
`endif
  always_ff @(posedge iClk)
    if (!nRst) begin
      state     <= IDLE;
      op_rd     <= 1'b0;
      op_wr     <= 1'b0;
      oRData    <= '0;
      oBusAddr  <= '0;
      oBusWData <= '0;
    end else begin
      state <= next;
      if (acc) begin
        oBusAddr <= iAddr;
        op_rd    <= iRead;
        op_wr    <= iWrite;
        if (iWrite) oBusWData <= iWData;
      end
      if (state == REQ && op_rd && iBusAck) oRData <= iBusRData;
      else if (tmo && op_rd) oRData <= '1;
    end
  always_comb
    next = state == IDLE ? (acc ? REQ : IDLE) :
           state == REQ  ? ((iBusAck || tmo) ? DONE : REQ) : IDLE;
  always_comb begin
    oBusRE = state == REQ && op_rd;
    oBusWE = state == REQ && op_wr;
    oRdy   = state == DONE || (state == IDLE && !iRead && !iWrite);
    oErr   = state == IDLE ? (iRead && iWrite) : (state == DONE && to_flag);
  end
endmodule

// File: tb/tb_mem_interface.sv
// tb_mem_interface: directed self-checking bench for mem_interface (TIMEOUT=4).
module tb_mem_interface;
  logic        iClk = 1'b0, nRst = 1'b0;
  logic [31:0] iAddr = '0, iWData = '0, iBusRData = '0;
  logic        iRead = 1'b0, iWrite = 1'b0, iBusAck = 1'b0;
  logic [31:0] oRData, oBusAddr, oBusWData;
  logic        oRdy, oErr, oBusRE, oBusWE;
  int checks = 0, errors = 0;

  mem_interface #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .iClk(iClk), .nRst(nRst), .iAddr(iAddr), .iRead(iRead), .iWrite(iWrite),
    .iWData(iWData), .oRData(oRData), .oRdy(oRdy), .oErr(oErr),
    .oBusAddr(oBusAddr), .oBusWData(oBusWData), .oBusRE(oBusRE), .oBusWE(oBusWE),
    .iBusAck(iBusAck), .iBusRData(iBusRData)
  );

  always #5 iClk = ~iClk;

  // Inputs change at the falling edge; outputs are checked 1ns later.
  task automatic cyc();
    @(negedge iClk);
  endtask

  task automatic test_reset();
    nRst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc();
      iAddr = $urandom; iWData = $urandom; iBusRData = $urandom;
      iRead = 1'($urandom); iWrite = 1'($urandom); iBusAck = 1'($urandom);
    end
    cyc();
    nRst = 1'b1; iRead = 1'b0; iWrite = 1'b0; iBusAck = 1'b0; #1;
    checks++; if (oRData !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp %h", oRData, 32'h0); end
    checks++; if ({oBusRE, oBusWE} !== 2'b00) begin errors++; $display("FAIL reset_strobes got %b exp 00", {oBusRE, oBusWE}); end
    checks++; if (oErr !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", oErr); end
    checks++; if (oRdy !== 1'b1) begin errors++; $display("FAIL reset_rdy got %b exp 1", oRdy); end
    checks++; if (oBusAddr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", oBusAddr); end
  endtask

  task automatic test_zero_wait_read();
    cyc(); iRead = 1'b1; iAddr = 32'h10; #1;
    checks++; if (oRdy !== 1'b0) begin errors++; $display("FAIL zr_c0_rdy got %b exp 0", oRdy); end
    cyc(); iBusAck = 1'b1; iBusRData = 32'hCAFEBABE; iAddr = 32'h77; #1;
    checks++; if (oBusRE !== 1'b1 || oBusWE !== 1'b0) begin errors++; $display("FAIL zr_c1_strobes got %b%b exp 10", oBusRE, oBusWE); end
    checks++; if (oBusAddr !== 32'h10) begin errors++; $display("FAIL zr_c1_addr got %h exp 00000010", oBusAddr); end
    checks++; if (oRdy !== 1'b0) begin errors++; $display("FAIL zr_c1_rdy got %b exp 0", oRdy); end
    cyc(); iBusAck = 1'b0; iRead = 1'b0; #1;
    checks++; if (oRdy !== 1'b1) begin errors++; $display("FAIL zr_c2_rdy got %b exp 1", oRdy); end
    checks++; if (oRData !== 32'hCAFEBABE) begin errors++; $display("FAIL zr_c2_rdata got %h exp cafebabe", oRData); end
    checks++; if (oBusRE !== 1'b0) begin errors++; $display("FAIL zr_c2_re got %b exp 0", oBusRE); end
    cyc(); #1;
    checks++; if (oRdy !== 1'b1 || oErr !== 1'b0) begin errors++; $display("FAIL zr_idle got rdy %b err %b exp 1 0", oRdy, oErr); end
  endtask

  task automatic test_wait_write();
    cyc(); iWrite = 1'b1; iAddr = 32'h20; iWData = 32'h12345678; #1;
    for (int c = 1; c <= 3; c++) begin
      cyc(); iAddr = 32'h99 + c; iWData = 32'hDEAD0000 + c; iBusAck = (c == 3); iBusRData = 32'h0BADF00D; #1;
      checks++; if (oBusWE !== 1'b1 || oBusRE !== 1'b0) begin errors++; $display("FAIL ww_c%0d_strobes got %b%b exp 01", c, oBusRE, oBusWE); end
      checks++; if (oBusAddr !== 32'h20) begin errors++; $display("FAIL ww_c%0d_addr got %h exp 00000020", c, oBusAddr); end
      checks++; if (oBusWData !== 32'h12345678) begin errors++; $display("FAIL ww_c%0d_wdata got %h exp 12345678", c, oBusWData); end
      checks++; if (oRdy !== 1'b0) begin errors++; $display("FAIL ww_c%0d_rdy got %b exp 0", c, oRdy); end
    end
    cyc(); iBusAck = 1'b0; iWrite = 1'b0; #1;
    checks++; if (oRdy !== 1'b1 || oBusWE !== 1'b0) begin errors++; $display("FAIL ww_done got rdy %b we %b exp 1 0", oRdy, oBusWE); end
    checks++; if (oRData !== 32'hCAFEBABE) begin errors++; $display("FAIL ww_rdata_kept got %h exp cafebabe", oRData); end
  endtask

  task automatic test_conflict();
    cyc(); iRead = 1'b1; iWrite = 1'b1; iAddr = 32'h50; iBusAck = 1'b1; #1;
    for (int c = 0; c < 2; c++) begin
      checks++; if (oErr !== 1'b1 || oRdy !== 1'b0) begin errors++; $display("FAIL cf_c%0d got err %b rdy %b exp 1 0", c, oErr, oRdy); end
      checks++; if ({oBusRE, oBusWE} !== 2'b00) begin errors++; $display("FAIL cf_c%0d_strobes got %b exp 00", c, {oBusRE, oBusWE}); end
      cyc(); #1;
    end
    iRead = 1'b0; iWrite = 1'b0; iBusAck = 1'b0; #1;
    checks++; if (oErr !== 1'b0 || oRdy !== 1'b1) begin errors++; $display("FAIL cf_release got err %b rdy %b exp 0 1", oErr, oRdy); end
    cyc(); #1;
    checks++; if ({oBusRE, oBusWE, oRdy} !== 3'b001 || oBusAddr !== 32'h20) begin errors++; $display("FAIL cf_no_access got re/we/rdy %b addr %h exp 001 00000020", {oBusRE, oBusWE, oRdy}, oBusAddr); end
  endtask

`ifdef MEM_IF_TIMEOUT_EN
  task automatic test_timeout();
    cyc(); iRead = 1'b1; iAddr = 32'h30; #1;
    for (int c = 1; c <= 4; c++) begin
      cyc(); #1;
      checks++; if (oBusRE !== 1'b1 || oErr !== 1'b0 || oRdy !== 1'b0) begin errors++; $display("FAIL to_c%0d got re %b err %b rdy %b exp 1 0 0", c, oBusRE, oErr, oRdy); end
    end
    cyc(); iRead = 1'b0; #1;
    checks++; if (oRdy !== 1'b1 || oErr !== 1'b1 || oBusRE !== 1'b0) begin errors++; $display("FAIL to_done got rdy %b err %b re %b exp 1 1 0", oRdy, oErr, oBusRE); end
    checks++; if (oRData !== 32'hFFFFFFFF) begin errors++; $display("FAIL to_rdata got %h exp ffffffff", oRData); end
    cyc(); #1;
    checks++; if (oErr !== 1'b0 || oRdy !== 1'b1) begin errors++; $display("FAIL to_after got err %b rdy %b exp 0 1", oErr, oRdy); end
  endtask
`else
  task automatic test_timeout();
    cyc(); iRead = 1'b1; iAddr = 32'h30; #1;
    for (int c = 1; c <= 20; c++) begin
      cyc(); #1;
      checks++; if (oBusRE !== 1'b1 || oRdy !== 1'b0 || oErr !== 1'b0) begin errors++; $display("FAIL nt_c%0d got re %b rdy %b err %b exp 1 0 0", c, oBusRE, oRdy, oErr); end
    end
    cyc(); iBusAck = 1'b1; iBusRData = 32'h55AA55AA; #1;
    cyc(); iBusAck = 1'b0; iRead = 1'b0; #1;
    checks++; if (oRdy !== 1'b1 || oErr !== 1'b0 || oRData !== 32'h55AA55AA) begin errors++; $display("FAIL nt_done got rdy %b err %b rdata %h exp 1 0 55aa55aa", oRdy, oErr, oRData); end
  endtask
`endif

  task automatic test_back_to_back();
    cyc(); iRead = 1'b1; iAddr = 32'h60; iBusAck = 1'b1; iBusRData = 32'h11112222; #1;
    cyc(); #1;
    cyc(); iAddr = 32'h64; iBusRData = 32'h33334444; iBusAck = 1'b0; #1;
    checks++; if (oRdy !== 1'b1 || oRData !== 32'h11112222) begin errors++; $display("FAIL bb_done1 got rdy %b rdata %h exp 1 11112222", oRdy, oRData); end
    cyc(); #1;
    checks++; if (oRdy !== 1'b0 || oBusRE !== 1'b0) begin errors++; $display("FAIL bb_idle_held got rdy %b re %b exp 0 0", oRdy, oBusRE); end
    cyc(); iBusAck = 1'b1; #1;
    checks++; if (oBusRE !== 1'b1 || oBusAddr !== 32'h64) begin errors++; $display("FAIL bb_req2 got re %b addr %h exp 1 00000064", oBusRE, oBusAddr); end
    cyc(); iBusAck = 1'b0; iRead = 1'b0; #1;
    checks++; if (oRdy !== 1'b1 || oRData !== 32'h33334444) begin errors++; $display("FAIL bb_done2 got rdy %b rdata %h exp 1 33334444", oRdy, oRData); end
  endtask

  task automatic test_reset_mid_access();
    cyc(); iWrite = 1'b1; iAddr = 32'h40; iWData = 32'hA5A5A5A5; #1;
    cyc(); #1;
    cyc(); nRst = 1'b0; #1;
    checks++; if (oBusWE !== 1'b1) begin errors++; $display("FAIL rm_req2_we got %b exp 1", oBusWE); end
    cyc(); nRst = 1'b1; iWrite = 1'b0; #1;
    checks++; if (oBusWE !== 1'b0 || oRdy !== 1'b1 || oBusAddr !== 32'h0) begin errors++; $display("FAIL rm_after got we %b rdy %b addr %h exp 0 1 0", oBusWE, oRdy, oBusAddr); end
    iBusAck = 1'b1; iBusRData = 32'h99999999;
    cyc(); iBusAck = 1'b0; #1;
    checks++; if (oRdy !== 1'b1 || {oBusRE, oBusWE} !== 2'b00 || oRData !== 32'h0) begin errors++; $display("FAIL rm_stray_ack got rdy %b strobes %b rdata %h exp 1 00 0", oRdy, {oBusRE, oBusWE}, oRData); end
  endtask

  initial begin
    test_reset();
    test_zero_wait_read();
    test_wait_write();
    test_conflict();
    test_timeout();
    test_back_to_back();
    test_reset_mid_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
